// File: rtl/acc4_arbiter_if.sv
// -----------------------------------------------------------------------------
// acc4_arbiter_if
// Bundle of the requester-side and result-side signals of acc4_arbiter.
//
// Parameters
//   IDW : requester ID width (NREQ = 2**IDW requesters)
//   DW  : sample width
//   SW  : sum width
//
// Signals
//   req_in    : per-requester request level
//   d_in      : flattened sample buses, requester k on [k*DW +: DW]
//   grant_out : one-hot grant
//   busy_out  : accumulator in use
//   valid_out : one-cycle result strobe
//   data_out  : accumulated sum, held until the next valid_out
//   id_out    : requester that owns data_out
//
// Modports
//   master : producer/consumer environment (drives requests and samples)
//   slave  : the arbiter itself
// -----------------------------------------------------------------------------
interface acc4_arbiter_if #(
  parameter int IDW = 2,
  parameter int DW  = 8,
  parameter int SW  = 11
);
  localparam int NREQ = 2 ** IDW;

  logic [NREQ-1:0]    req_in;
  logic [NREQ*DW-1:0] d_in;
  logic [NREQ-1:0]    grant_out;
  logic               busy_out;
  logic               valid_out;
  logic [SW-1:0]      data_out;
  logic [IDW-1:0]     id_out;

  modport master (
    output req_in, d_in,
    input  grant_out, busy_out, valid_out, data_out, id_out
  );

  modport slave (
    input  req_in, d_in,
    output grant_out, busy_out, valid_out, data_out, id_out
  );
endinterface

// File: rtl/acc4_arbiter.sv
// -----------------------------------------------------------------------------
// acc4_arbiter
// Shares one BEATS-sample summing accumulator between NREQ requesters. A
// winner is chosen in IDLE, granted for exactly BEATS cycles while its samples
// are summed, and the result is returned with a one-cycle valid_out pulse
// tagged with the owner's ID.
//
// Parameters
//   IDW   : requester ID width (NREQ = 2**IDW)
//   DW    : sample width
//   BEATS : samples per transaction (>= 1)
//   SW    : sum width (sum wraps modulo 2**SW)
//
// Ports
//   clk : clock, all state on the rising edge
//   rst : synchronous active-high reset
//   bus : acc4_arbiter_if.slave (req_in, d_in in; grant_out, busy_out,
//         valid_out, data_out, id_out out)
//
// Configuration
//   ACC4_ARB_ROUND_ROBIN_EN defined : round-robin winner selection starting at
//                                     a rotating pointer.
//   undefined (default)             : fixed priority, lowest index wins.
// -----------------------------------------------------------------------------
module acc4_arbiter #(
  parameter int IDW   = 2,
  parameter int DW    = 8,
  parameter int BEATS = 4,
  parameter int SW    = 11
) (
  input  logic          clk,
  input  logic          rst,
  acc4_arbiter_if.slave bus
);

  localparam int NREQ = 2 ** IDW;
  localparam int CW   = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   beat_cnt;
  logic [IDW-1:0]  owner;
  logic [SW-1:0]   sum;
  logic [IDW-1:0]  winner;
  logic [IDW-1:0]  idx;
  logic            found;
  logic            any_req;
  logic [DW-1:0]   owner_d;
  logic [SW-1:0]   sum_next;

`ifdef ACC4_ARB_ROUND_ROBIN_EN
  logic [IDW-1:0]  ptr;
`endif

  assign any_req  = |bus.req_in;
  assign owner_d  = bus.d_in[owner*DW +: DW];
  // Sample is zero-extended; the add wraps modulo 2**SW by truncation.
  assign sum_next = sum + SW'(owner_d);

  // Winner search: first set request at or after the start index, wrapping.
  // IDW-bit index arithmetic wraps modulo NREQ for free.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 0; i < NREQ; i++) begin
`ifdef ACC4_ARB_ROUND_ROBIN_EN
      idx = ptr + IDW'(i);
`else
      idx = IDW'(i);
`endif
      if (!found && bus.req_in[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  // Single FSM block; all outputs are registers updated alongside the state so
  // grant_out/busy_out line up exactly with the ACC/DONE cycles.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees pre-edge values regardless of statement order.
    if (rst) begin
      state         <= IDLE;
      beat_cnt      <= '0;
      owner         <= '0;
      sum           <= '0;
      bus.grant_out <= '0;
      bus.busy_out  <= 1'b0;
      bus.valid_out <= 1'b0;
      bus.data_out  <= '0;
      bus.id_out    <= '0;
`ifdef ACC4_ARB_ROUND_ROBIN_EN
      ptr           <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          bus.valid_out <= 1'b0;
          if (any_req) begin
            owner         <= winner;
            beat_cnt      <= CW'(BEATS - 1);
            sum           <= '0;
            bus.grant_out <= NREQ'(1) << winner;
            bus.busy_out  <= 1'b1;
            state         <= ACC;
`ifdef ACC4_ARB_ROUND_ROBIN_EN
            ptr           <= winner + IDW'(1);
`endif
          end
        end

        // Samples are taken from the owner's bus regardless of its request.
        ACC: begin
          sum <= sum_next;
          if (beat_cnt == '0) begin
            bus.grant_out <= '0;
            bus.valid_out <= 1'b1;
            bus.data_out  <= sum_next;
            bus.id_out    <= owner;
            state         <= DONE;
          end else begin
            beat_cnt <= beat_cnt - CW'(1);
          end
        end

        DONE: begin
          bus.valid_out <= 1'b0;
          bus.busy_out  <= 1'b0;
          state         <= IDLE;
        end

        default: begin
          bus.grant_out <= '0;
          bus.busy_out  <= 1'b0;
          bus.valid_out <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acc4_arbiter.sv
// -----------------------------------------------------------------------------
// tb_acc4_arbiter
// Self-checking bench for acc4_arbiter (default parameters). A transaction-
// level reference model tracks when each transaction started and derives the
// expected grant/busy/valid windows and the sum from those times. Works for
// both builds: the model follows ACC4_ARB_ROUND_ROBIN_EN for winner selection.
// -----------------------------------------------------------------------------
module tb_acc4_arbiter;

  localparam int IDW   = 2;
  localparam int DW    = 8;
  localparam int BEATS = 4;
  localparam int SW    = 11;
  localparam int NREQ  = 2 ** IDW;

  logic clk;
  logic rst;

  acc4_arbiter_if #(.IDW(IDW), .DW(DW), .SW(SW)) bus ();

  acc4_arbiter #(.IDW(IDW), .DW(DW), .BEATS(BEATS), .SW(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction windows) ----------------
  int  edge_n  = 0;  // index of the edge just taken
  bit  m_active = 1'b0;
  int  m_start  = 0; // edge at which the current transaction won arbitration
  int  m_owner  = 0;
  int  m_acc    = 0;
  int  m_ptr    = 0;
  int  m_free   = 0; // first edge at which arbitration may happen again
  int  m_data   = 0;
  int  m_id     = 0;

  typedef struct { int id; int data; } result_t;
  result_t res_q[$];

  function automatic int pick(input logic [NREQ-1:0] r, input int start);
    for (int i = 0; i < NREQ; i++) begin
      int k;
`ifdef ACC4_ARB_ROUND_ROBIN_EN
      k = (start + i) % NREQ;
`else
      k = i;
`endif
      if (r[k]) return k;
    end
    return -1;
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_active = 1'b0;
      m_free   = edge_n + 1;
      m_data   = 0;
      m_id     = 0;
      m_ptr    = 0;
      return;
    end
    if (m_active && edge_n >= m_start + 1 && edge_n <= m_start + BEATS)
      m_acc += int'(bus.d_in[m_owner*DW +: DW]);
    if (m_active && edge_n == m_start + BEATS) begin
      m_data = m_acc % (1 << SW);
      m_id   = m_owner;
    end
    if (m_active && edge_n == m_start + BEATS + 1)
      m_active = 1'b0;
    if (!m_active && edge_n >= m_free && bus.req_in != '0) begin
      m_owner  = pick(bus.req_in, m_ptr);
      m_ptr    = (m_owner + 1) % NREQ;
      m_active = 1'b1;
      m_start  = edge_n;
      m_acc    = 0;
      m_free   = edge_n + BEATS + 2;
    end
  endtask

  // One clock: drive at negedge, take the edge, check #1 later.
  task automatic step(input logic [NREQ-1:0] r, input logic [NREQ*DW-1:0] d, input logic rr);
    logic [NREQ-1:0] eg;
    bit eb, ev;
    @(negedge clk);
    bus.req_in = r;
    bus.d_in   = d;
    rst        = rr;
    @(posedge clk);
    edge_n++;
    model_edge();
    #1;
    eg = (m_active && edge_n <= m_start + BEATS - 1) ? NREQ'(1) << m_owner : '0;
    eb = m_active && edge_n <= m_start + BEATS;
    ev = m_active && edge_n == m_start + BEATS;
    check("grant", 32'(bus.grant_out), 32'(eg));
    check("busy",  32'(bus.busy_out),  32'(eb));
    check("valid", 32'(bus.valid_out), 32'(ev));
    check("data",  32'(bus.data_out),  32'(m_data));
    check("id",    32'(bus.id_out),    32'(m_id));
    if (ev) res_q.push_back('{id: int'(bus.id_out), data: int'(bus.data_out)});
  endtask

  task automatic do_reset();
    step('0, '0, 1'b1);
    step('0, '0, 1'b1);
    res_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    result_t r;
    bus.req_in = '0;
    bus.d_in   = '0;
    rst        = 1'b1;

    // Reset state.
    do_reset();
    check("rst_grant", 32'(bus.grant_out), 32'd0);
    check("rst_valid", 32'(bus.valid_out), 32'd0);
    check("rst_data",  32'(bus.data_out),  32'd0);

    // Single requester 0, samples 10,20,30,40.
    step(4'b0001, 32'd0,  1'b0);
    step(4'b0001, 32'd10, 1'b0);
    step(4'b0001, 32'd20, 1'b0);
    step(4'b0001, 32'd30, 1'b0);
    step(4'b0001, 32'd40, 1'b0);
    check("t1_valid", 32'(bus.valid_out), 32'd1);
    check("t1_data",  32'(bus.data_out),  32'd100);
    check("t1_id",    32'(bus.id_out),    32'd0);
    step(4'b0000, 32'd0, 1'b0);
    step(4'b0000, 32'd0, 1'b0);

    // All four requesting, requester k drives k+1.
    do_reset();
    for (int i = 0; i < 5 * (BEATS + 2); i++)
      step(4'b1111, {8'd4, 8'd3, 8'd2, 8'd1}, 1'b0);
    check("t2_count", 32'(res_q.size()), 32'd5);
    for (int t = 0; t < 5 && t < res_q.size(); t++) begin
`ifdef ACC4_ARB_ROUND_ROBIN_EN
      check("t2_id",   32'(res_q[t].id),   32'(t % 4));
      check("t2_data", 32'(res_q[t].data), 32'(4 * ((t % 4) + 1)));
`else
      check("t2_id",   32'(res_q[t].id),   32'd0);
      check("t2_data", 32'(res_q[t].data), 32'd4);
`endif
    end

    // Requester 2 at full scale: no overflow at SW=11.
    do_reset();
    for (int i = 0; i < BEATS + 2; i++)
      step(4'b0100, {8'd0, 8'd255, 8'd0, 8'd0}, 1'b0);
    check("t3_count", 32'(res_q.size()), 32'd1);
    if (res_q.size() > 0) begin
      r = res_q[0];
      check("t3_data", 32'(r.data), 32'd1020);
      check("t3_id",   32'(r.id),   32'd2);
    end

    // Reset during the third grant cycle, then a fresh transaction.
    do_reset();
    step(4'b0010, {8'd0, 8'd0, 8'd50, 8'd0}, 1'b0);
    step(4'b0010, {8'd0, 8'd0, 8'd50, 8'd0}, 1'b0);
    step(4'b0010, {8'd0, 8'd0, 8'd50, 8'd0}, 1'b0);
    step(4'b0010, {8'd0, 8'd0, 8'd50, 8'd0}, 1'b1);
    check("t4_grant", 32'(bus.grant_out), 32'd0);
    check("t4_busy",  32'(bus.busy_out),  32'd0);
    for (int i = 0; i < BEATS + 2; i++)
      step(4'b0010, {8'd0, 8'd0, 8'd7, 8'd0}, 1'b0);
    check("t4_count", 32'(res_q.size()), 32'd1);
    if (res_q.size() > 0) check("t4_data", 32'(res_q[0].data), 32'd28);

    // Owner drops its request after the first grant cycle.
    do_reset();
    step(4'b1000, {8'd9, 24'd0}, 1'b0);
    for (int i = 0; i < BEATS + 1; i++)
      step(4'b0000, {8'd9, 24'd0}, 1'b0);
    check("t5_count", 32'(res_q.size()), 32'd1);
    if (res_q.size() > 0) begin
      check("t5_data", 32'(res_q[0].data), 32'd36);
      check("t5_id",   32'(res_q[0].id),   32'd3);
    end

    // Randomized traffic with occasional resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [NREQ-1:0] rq;
      int mode;
      mode = $urandom_range(0, 3);
      case (mode)
        0:       rq = '0;
        1:       rq = NREQ'(1) << $urandom_range(0, NREQ - 1);
        default: rq = NREQ'($urandom);
      endcase
      step(rq, $urandom, ($urandom_range(0, 199) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
